// File: rtl/serial_2wire_arbiter.sv
// serial_2wire_arbiter
// Shares a single serial_2wire master between NUM_REQ requesters using
// round-robin arbitration with transaction-level locking. The owner keeps
// the bus until it drops enable and the bus reports ready again.
// Optional build macro: SERIAL_ARB_TIMEOUT_EN (forces release of an owner
// that holds the bus for MAX_HOLD_CYCLES cycles).
module serial_2wire_arbiter #(
    parameter int NUM_REQ         = 2,
    parameter int BITS            = 8,
    parameter int ADDR_BITS       = 8,
    parameter int MAX_HOLD_CYCLES = 1_000_000
) (
    input  logic                          in_clk,
    input  logic                          in_rst,
    input  logic [NUM_REQ-1:0]            in_req_enable,
    input  logic [NUM_REQ-1:0]            in_req_write,
    input  logic [NUM_REQ*ADDR_BITS-1:0]  in_req_addr_write,
    input  logic [NUM_REQ*ADDR_BITS-1:0]  in_req_addr_read,
    input  logic [NUM_REQ*BITS-1:0]       in_req_data,
    output logic [NUM_REQ-1:0]            out_req_ready,
    output logic [NUM_REQ-1:0]            out_req_next_word,
    output logic [NUM_REQ-1:0]            out_req_error,
    output logic [BITS-1:0]               out_req_data,
    output logic [NUM_REQ-1:0]            out_grant,
    output logic [NUM_REQ-1:0]            out_timeout,
    output logic                          out_bus_enable,
    output logic                          out_bus_write,
    output logic [ADDR_BITS-1:0]          out_bus_addr_write,
    output logic [ADDR_BITS-1:0]          out_bus_addr_read,
    output logic [BITS-1:0]               out_bus_data,
    input  logic                          in_bus_ready,
    input  logic                          in_bus_next_word,
    input  logic                          in_bus_error,
    input  logic [BITS-1:0]               in_bus_data
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] grant_idx_reg, grant_idx_next;
    logic [IDX_W-1:0] last_grant_reg, last_grant_next;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_valid;
    logic             timeout_hit;
    logic             route_en;
    logic             sel_enable;

    logic [ADDR_BITS-1:0] addr_write_arr [NUM_REQ];
    logic [ADDR_BITS-1:0] addr_read_arr  [NUM_REQ];
    logic [BITS-1:0]      data_arr       [NUM_REQ];

    // Owner-side routing is active while a grant is held (BUSY or RELEASE)
    assign route_en   = (state_reg != ST_IDLE);
    assign sel_enable = in_req_enable[grant_idx_reg];

    // Per-requester unpacking of the flattened buses and owner-only routing back
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign addr_write_arr[gi]    = in_req_addr_write[gi*ADDR_BITS +: ADDR_BITS];
            assign addr_read_arr[gi]     = in_req_addr_read[gi*ADDR_BITS +: ADDR_BITS];
            assign data_arr[gi]          = in_req_data[gi*BITS +: BITS];
            assign out_grant[gi]         = route_en && (grant_idx_reg == IDX_W'(gi));
            assign out_req_ready[gi]     = out_grant[gi] && in_bus_ready;
            assign out_req_next_word[gi] = out_grant[gi] && in_bus_next_word;
            assign out_req_error[gi]     = out_grant[gi] && in_bus_error;
            assign out_timeout[gi]       = out_grant[gi] && timeout_hit;
        end
    endgenerate

`ifdef SERIAL_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_HOLD_CYCLES + 1);
    logic [CNT_W-1:0] hold_cnt_reg;

    // Hold counter: zero outside BUSY, so it starts at 0 on the first BUSY cycle
    always_ff @(posedge in_clk) begin
        if (in_rst || state_reg != ST_BUSY) begin
            hold_cnt_reg <= '0;
        end else begin
            hold_cnt_reg <= hold_cnt_reg + 1'b1;
        end
    end

    assign timeout_hit = (state_reg == ST_BUSY) &&
                         (hold_cnt_reg == CNT_W'(MAX_HOLD_CYCLES - 1));
`else
    // Unlimited hold time: never forces a release
    assign timeout_hit = 1'b0;
`endif

    // Round-robin search starting just after the last owner; the loop runs
    // from the farthest candidate down so the nearest requesting one wins
    always_comb begin
        int cand;
        pick_idx   = '0;
        pick_valid = 1'b0;
        cand       = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = (int'(last_grant_reg) + k) % NUM_REQ;
            if (in_req_enable[IDX_W'(cand)]) begin
                pick_idx   = IDX_W'(cand);
                pick_valid = 1'b1;
            end
        end
    end

    // Next-state logic: grant in IDLE, watch the owner in BUSY, wait for bus ready in RELEASE
    always_comb begin
        state_next      = state_reg;
        grant_idx_next  = grant_idx_reg;
        last_grant_next = last_grant_reg;
        case (state_reg)
            ST_IDLE: begin
                if (pick_valid && in_bus_ready) begin
                    grant_idx_next = pick_idx;
                    state_next     = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (!sel_enable || timeout_hit) begin
                    state_next = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (in_bus_ready) begin
                    last_grant_next = grant_idx_reg;
                    state_next      = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State registers; reset makes requester 0 the first round-robin winner
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state_reg      <= ST_IDLE;
            grant_idx_reg  <= '0;
            last_grant_reg <= IDX_W'(NUM_REQ - 1);
        end else begin
            state_reg      <= state_next;
            grant_idx_reg  <= grant_idx_next;
            last_grant_reg <= last_grant_next;
        end
    end

    // Bus-side mux; enable only passes through in BUSY and is killed by reset at once
    assign out_bus_enable     = (state_reg == ST_BUSY) && sel_enable && !timeout_hit && !in_rst;
    assign out_bus_write      = in_req_write[grant_idx_reg];
    assign out_bus_addr_write = addr_write_arr[grant_idx_reg];
    assign out_bus_addr_read  = addr_read_arr[grant_idx_reg];
    assign out_bus_data       = data_arr[grant_idx_reg];

    // Read data is broadcast unregistered
    assign out_req_data = in_bus_data;

endmodule
